// File: rtl/mux_4bit_rr_sequencer_if.sv
// Handshake bundle between the round-robin mux sequencer, the 4:1 mux it steers
// and the downstream consumer of the captured mux output.
interface mux_4bit_rr_sequencer_if #(
    parameter int WIDTH = 4
);
    logic [3:0]       REQ;
    logic [1:0]       SEL;
    logic             E;
    logic [WIDTH-1:0] Y;
    logic [3:0]       GNT;
    logic [WIDTH-1:0] OUT_DATA;
    logic             OUT_VALID;
    logic             OUT_READY;
    logic             TIMEOUT;

    modport master (
        input  REQ, Y, OUT_READY,
        output SEL, E, GNT, OUT_DATA, OUT_VALID, TIMEOUT
    );

    modport slave (
        output REQ, Y, OUT_READY,
        input  SEL, E, GNT, OUT_DATA, OUT_VALID, TIMEOUT
    );
endinterface

// File: rtl/mux_4bit_rr_sequencer.sv
// Round-robin sequencer for a 4-bit 4:1 mux: grants a requester, pulses the mux enable,
// captures Y and offers it on a valid/ready port. MUX_SEQ_TIMEOUT_EN adds a backpressure timeout.
module mux_4bit_rr_sequencer #(
    parameter int WIDTH          = 4,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                    clk,
    input  logic                    rst_n,
    mux_4bit_rr_sequencer_if.master bus
);
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_OUTPUT = 2'd2
    } state_t;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_t           state_q, state_d;
    logic [1:0]       sel_q, sel_d;
    logic [1:0]       ptr_q, ptr_d;
    logic             e_q, e_d;
    logic [3:0]       gnt_q, gnt_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             req_any_s;
    logic [1:0]       req_idx_s;

`ifdef MUX_SEQ_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          timeout_q, timeout_d;
`endif

    // Walk downward so the lowest offset from ptr (the highest-priority channel) wins.
    function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
        logic [2:0] pick;
        logic [1:0] idx;
        pick = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            idx = ptr + 2'(i);
            if (req[idx]) begin
                pick = {1'b1, idx};
            end else begin
                pick = pick;
            end
        end
        return pick;
    endfunction

    assign {req_any_s, req_idx_s} = rr_pick(bus.REQ, ptr_q);

    // Next-state and next-output computation for the IDLE/DRIVE/OUTPUT sequence.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        ptr_d       = ptr_q;
        e_d         = e_q;
        gnt_d       = gnt_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
`ifdef MUX_SEQ_TIMEOUT_EN
        cnt_d       = cnt_q;
        timeout_d   = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req_any_s) begin
                    sel_d   = req_idx_s;
                    gnt_d   = 4'b0001 << req_idx_s;
                    e_d     = 1'b1;
                    state_d = ST_DRIVE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRIVE: begin
                out_data_d  = bus.Y;
                out_valid_d = 1'b1;
                e_d         = 1'b0;
                state_d     = ST_OUTPUT;
`ifdef MUX_SEQ_TIMEOUT_EN
                cnt_d       = {CW{1'b0}};
`endif
            end
            ST_OUTPUT: begin
                if (bus.OUT_READY) begin
                    out_valid_d = 1'b0;
                    gnt_d       = 4'b0000;
                    ptr_d       = sel_q + 2'd1;
                    state_d     = ST_IDLE;
`ifdef MUX_SEQ_TIMEOUT_EN
                end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    // The count would reach the limit on this edge: drop the word.
                    out_valid_d = 1'b0;
                    gnt_d       = 4'b0000;
                    ptr_d       = sel_q + 2'd1;
                    timeout_d   = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    cnt_d       = cnt_q + CW'(1);
                end
`else
                end else begin
                    state_d = ST_OUTPUT;
                end
`endif
            end
            default: begin
                state_d     = ST_IDLE;
                e_d         = 1'b0;
                gnt_d       = 4'b0000;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset discards any transfer in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            sel_q       <= 2'd0;
            ptr_q       <= 2'd0;
            e_q         <= 1'b0;
            gnt_q       <= 4'b0000;
            out_data_q  <= {WIDTH{1'b0}};
            out_valid_q <= 1'b0;
`ifdef MUX_SEQ_TIMEOUT_EN
            cnt_q       <= {CW{1'b0}};
            timeout_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            ptr_q       <= ptr_d;
            e_q         <= e_d;
            gnt_q       <= gnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
`ifdef MUX_SEQ_TIMEOUT_EN
            cnt_q       <= cnt_d;
            timeout_q   <= timeout_d;
`endif
        end
    end

    assign bus.SEL       = sel_q;
    assign bus.E         = e_q;
    assign bus.GNT       = gnt_q;
    assign bus.OUT_DATA  = out_data_q;
    assign bus.OUT_VALID = out_valid_q;
`ifdef MUX_SEQ_TIMEOUT_EN
    assign bus.TIMEOUT   = timeout_q;
`else
    assign bus.TIMEOUT   = 1'b0;
`endif
endmodule

// File: tb/tb_mux_4bit_rr_sequencer.sv
// Self-checking bench for mux_4bit_rr_sequencer: table of transfers plus reset and timeout
// sequences; accepted words are checked against a queue of expected values.
module tb_mux_4bit_rr_sequencer;
    typedef struct {
        logic [3:0] req;
        int         stall;
        logic [1:0] sel;
        logic [3:0] data;
        bit         drop;
    } vec_t;

    logic       clk;
    logic       rst_n;
    int         n_checks   = 0;
    int         n_errors   = 0;
    int         n_accepts  = 0;
    int         n_expected = 0;
    logic [3:0] exp_q[$];
    vec_t       vecs[12];

    mux_4bit_rr_sequencer_if #(.WIDTH(4)) bus ();

    mux_4bit_rr_sequencer #(.WIDTH(4), .TIMEOUT_CYCLES(15)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Mux model: D0..D3 are one-hot constants, output forced to 0 while disabled.
    assign bus.Y = bus.E ? (4'b0001 << bus.SEL) : 4'b0000;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Scoreboard: every accepted word must match the oldest expected word.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.OUT_VALID === 1'b1 && bus.OUT_READY === 1'b1) begin
            n_accepts++;
            if (exp_q.size() == 0) begin
                check("sb_queue_nonempty", exp_q.size(), 32'd1);
            end else begin
                logic [3:0] e;
                e = exp_q.pop_front();
                check("sb_data", bus.OUT_DATA, e);
                check("sb_gnt", bus.GNT, e);
            end
        end
    end

    task automatic xfer(input vec_t v);
        bus.REQ       = v.req;
        bus.OUT_READY = (v.stall == 0);
        exp_q.push_back(v.data);
        n_expected++;
        tick();
        if (v.drop) bus.REQ = 4'b0000;
        @(negedge clk);
        check("drive_e", bus.E, 32'd1);
        check("drive_sel", bus.SEL, v.sel);
        check("drive_gnt", bus.GNT, v.data);
        check("drive_valid", bus.OUT_VALID, 32'd0);
        tick();
        @(negedge clk);
        check("out_valid", bus.OUT_VALID, 32'd1);
        check("out_data", bus.OUT_DATA, v.data);
        check("out_e", bus.E, 32'd0);
        check("out_sel", bus.SEL, v.sel);
        for (int k = 1; k < v.stall; k++) begin
            tick();
            @(negedge clk);
            check("bp_valid", bus.OUT_VALID, 32'd1);
            check("bp_data", bus.OUT_DATA, v.data);
        end
        if (v.stall > 0) begin
            tick();
            bus.OUT_READY = 1'b1;
            @(negedge clk);
        end
        tick();
        @(negedge clk);
        check("post_valid", bus.OUT_VALID, 32'd0);
        check("post_gnt", bus.GNT, 32'd0);
        check("post_e", bus.E, 32'd0);
        if (v.drop) begin
            tick();
            @(negedge clk);
            check("drop_idle_e", bus.E, 32'd0);
            check("drop_idle_valid", bus.OUT_VALID, 32'd0);
        end
    endtask

    initial begin
        vecs[0]  = '{4'b1111, 0, 2'd0, 4'b0001, 1'b0};
        vecs[1]  = '{4'b1111, 0, 2'd1, 4'b0010, 1'b0};
        vecs[2]  = '{4'b1111, 0, 2'd2, 4'b0100, 1'b0};
        vecs[3]  = '{4'b1111, 0, 2'd3, 4'b1000, 1'b0};
        vecs[4]  = '{4'b1111, 0, 2'd0, 4'b0001, 1'b0};
        vecs[5]  = '{4'b0100, 0, 2'd2, 4'b0100, 1'b0};
        vecs[6]  = '{4'b0001, 5, 2'd0, 4'b0001, 1'b0};
        vecs[7]  = '{4'b0010, 0, 2'd1, 4'b0010, 1'b1};
        vecs[8]  = '{4'b0101, 0, 2'd2, 4'b0100, 1'b0};
        vecs[9]  = '{4'b0011, 0, 2'd0, 4'b0001, 1'b0};
        vecs[10] = '{4'b1001, 0, 2'd3, 4'b1000, 1'b0};
        vecs[11] = '{4'b1100, 0, 2'd2, 4'b0100, 1'b0};

        rst_n         = 1'b0;
        bus.REQ       = 4'b0000;
        bus.OUT_READY = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        check("rst_sel", bus.SEL, 32'd0);
        check("rst_e", bus.E, 32'd0);
        check("rst_gnt", bus.GNT, 32'd0);
        check("rst_data", bus.OUT_DATA, 32'd0);
        check("rst_valid", bus.OUT_VALID, 32'd0);
        check("rst_timeout", bus.TIMEOUT, 32'd0);
        rst_n = 1'b1;
        tick();

        // Leave PTR at 3, then reset during OUTPUT; the round-robin table must restart at 0.
        xfer('{4'b0100, 0, 2'd2, 4'b0100, 1'b0});
        bus.REQ       = 4'b1000;
        bus.OUT_READY = 1'b0;
        tick();
        bus.REQ = 4'b0000;
        tick();
        @(negedge clk);
        check("pre_rst_valid", bus.OUT_VALID, 32'd1);
        check("pre_rst_data", bus.OUT_DATA, 32'h8);
        #1 rst_n = 1'b0;
        #1;
        check("arst_valid", bus.OUT_VALID, 32'd0);
        check("arst_data", bus.OUT_DATA, 32'd0);
        check("arst_gnt", bus.GNT, 32'd0);
        check("arst_sel", bus.SEL, 32'd0);
        check("arst_e", bus.E, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        check("post_rst_idle_e", bus.E, 32'd0);
        check("post_rst_idle_valid", bus.OUT_VALID, 32'd0);

        for (int i = 0; i < 12; i++) begin
            xfer(vecs[i]);
        end

        // PTR is now 3: channel 3 is granted and then held off by READY=0.
        bus.REQ       = 4'b1000;
        bus.OUT_READY = 1'b0;
        tick();
        bus.REQ = 4'b0000;
        tick();
        @(negedge clk);
        check("to_valid_rise", bus.OUT_VALID, 32'd1);
        check("to_data", bus.OUT_DATA, 32'h8);
`ifdef MUX_SEQ_TIMEOUT_EN
        for (int k = 1; k < 15; k++) begin
            tick();
            @(negedge clk);
            check("to_wait_valid", bus.OUT_VALID, 32'd1);
            check("to_wait_pulse", bus.TIMEOUT, 32'd0);
        end
        tick();
        @(negedge clk);
        check("to_pulse", bus.TIMEOUT, 32'd1);
        check("to_valid_drop", bus.OUT_VALID, 32'd0);
        check("to_gnt_drop", bus.GNT, 32'd0);
        tick();
        @(negedge clk);
        check("to_pulse_width", bus.TIMEOUT, 32'd0);
`else
        for (int k = 0; k < 20; k++) begin
            tick();
            @(negedge clk);
            check("noto_valid", bus.OUT_VALID, 32'd1);
            check("noto_data", bus.OUT_DATA, 32'h8);
            check("noto_timeout", bus.TIMEOUT, 32'd0);
        end
        tick();
        exp_q.push_back(4'b1000);
        n_expected++;
        bus.OUT_READY = 1'b1;
        @(negedge clk);
        tick();
        @(negedge clk);
        check("noto_accept_valid", bus.OUT_VALID, 32'd0);
`endif
        xfer('{4'b1111, 0, 2'd0, 4'b0001, 1'b0});
        bus.REQ = 4'b0000;
        tick();
        @(negedge clk);

        check("sb_drained", exp_q.size(), 32'd0);
        check("accept_count", n_accepts, n_expected);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
